uart_tx_buffered: RTL and testbench

UART transmitter that sends 8-bit bytes as 8N1 serial frames: one start bit, eight data bits LSB first, one stop bit, no parity. Idle line is high. It is the transmit counterpart of the FPGA co-processor's UART receive path and sits between the result/response logic and the physical TX pin. A small FIFO lets the producer queue several bytes, and queued bytes go out back-to-back with no idle gap.

---
 rtl/uart_tx_buffered_pkg.sv | 20 ++
 rtl/uart_tx_buffered_fifo.sv | 70 +++++++
 rtl/uart_tx_buffered.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_buffered_pkg.sv
// Shared UART definitions: FSM state codes, frame geometry and the bit-period formula
// used by both the transmit and receive paths so they agree on truncation.
package uart_tx_buffered_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;

  // Integer truncation on purpose: both ends must derive the identical bit period.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_fifo.sv
// Single-clock byte FIFO; fullness comes from the occupancy count so the
// naturally wrapping pointers never need an extra disambiguation bit.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign o_full   = (count_q == CW'(DEPTH));
  assign o_empty  = (count_q == '0);
  assign o_count  = count_q;
  assign o_data   = mem[rd_ptr_q];
  assign push_ok  = i_push & ~o_full;
  assign pop_ok   = i_pop & ~o_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr_q] <= i_data;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter fed by a small FIFO; queued bytes leave back-to-back,
// the next start bit beginning on the same edge that ends the previous stop bit.
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 25000000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_tx_valid,
  input  logic [7:0]                   i_tx_byte,
  output logic                         o_tx_ready,
  output logic                         o_tx_serial,
  output logic                         o_tx_active,
  output logic                         o_tx_done,
  output logic [$clog2(FIFO_DEPTH):0]  o_fifo_count
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int CNT_W        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT   = 3'(UART_DATA_BITS - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx_buffered: CLOCK_FREQUENCY / BAUD_RATE must be at least 2");
    end
  endgenerate

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             serial_q, serial_d;
  logic             active_q, active_d;
  logic             done_q, done_d;

  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_data;
  logic             push;

  assign o_tx_ready  = ~fifo_full;
  assign push        = i_tx_valid & o_tx_ready;
  assign o_tx_serial = serial_q;
  assign o_tx_active = active_q;
  assign o_tx_done   = done_q;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_data  (i_tx_byte),
    .i_pop   (fifo_pop),
    .o_data  (fifo_data),
    .o_count (o_fifo_count),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    serial_d   = serial_q;
    active_d   = active_q;
    done_d     = 1'b0;
    fifo_pop   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        serial_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_d    = fifo_data;
          serial_d   = 1'b0;
          active_d   = 1'b1;
          baud_cnt_d = CNT_RELOAD;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (baud_cnt_q == '0) begin
          serial_d   = shift_q[0];
          bit_idx_d  = '0;
          baud_cnt_d = CNT_RELOAD;
          state_d    = ST_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q - CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_cnt_q == '0) begin
          baud_cnt_d = CNT_RELOAD;
          if (bit_idx_q == LAST_BIT) begin
            serial_d = 1'b1;
            state_d  = ST_STOP;
          end else begin
            // Drive the bit that becomes shift[0] after this shift.
            shift_d   = shift_q >> 1;
            serial_d  = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_cnt_q == '0) begin
          done_d = 1'b1;
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            shift_d    = fifo_data;
            serial_d   = 1'b0;
            baud_cnt_d = CNT_RELOAD;
            state_d    = ST_START;
          end else begin
            active_d = 1'b0;
            state_d  = ST_IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        serial_d = 1'b1;
        active_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      serial_q   <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      serial_q   <= serial_d;
      active_q   <= active_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: a default-rate instance and a 3-clocks-per-bit instance,
// each checked against a frame-schedule model built from accept times and the 8N1 rules.
module tb_uart_tx_buffered;

  localparam int CPB_A = 25000000 / 115200;
  localparam int CPB_B = 1000000 / 300000;
  localparam int MAXC  = 32768;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       va, vb;
  logic [7:0] ba, bb;
  logic       ready_a, ser_a, act_a, done_a;
  logic       ready_b, ser_b, act_b, done_b;
  logic [2:0] cnt_a, cnt_b;

  always #5 clk = ~clk;

  uart_tx_buffered #(
    .CLOCK_FREQUENCY (25000000),
    .BAUD_RATE       (115200),
    .FIFO_DEPTH      (4)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_tx_valid   (va),
    .i_tx_byte    (ba),
    .o_tx_ready   (ready_a),
    .o_tx_serial  (ser_a),
    .o_tx_active  (act_a),
    .o_tx_done    (done_a),
    .o_fifo_count (cnt_a)
  );

  uart_tx_buffered #(
    .CLOCK_FREQUENCY (1000000),
    .BAUD_RATE       (300000),
    .FIFO_DEPTH      (4)
  ) dut_fast (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_tx_valid   (vb),
    .i_tx_byte    (bb),
    .o_tx_ready   (ready_b),
    .o_tx_serial  (ser_b),
    .o_tx_active  (act_b),
    .o_tx_done    (done_b),
    .o_fifo_count (cnt_b)
  );

  // Edge counter and per-edge output logs (index k = outputs after rising edge k).
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit ser_log  [2][MAXC];
  bit act_log  [2][MAXC];
  bit done_log [2][MAXC];
  bit rdy_log  [2][MAXC];
  int cnt_log  [2][MAXC];

  always @(negedge clk) begin
    if (cyc < MAXC) begin
      ser_log[0][cyc]  <= ser_a;   ser_log[1][cyc]  <= ser_b;
      act_log[0][cyc]  <= act_a;   act_log[1][cyc]  <= act_b;
      done_log[0][cyc] <= done_a;  done_log[1][cyc] <= done_b;
      rdy_log[0][cyc]  <= ready_a; rdy_log[1][cyc]  <= ready_b;
      cnt_log[0][cyc]  <= int'(cnt_a);
      cnt_log[1][cyc]  <= int'(cnt_b);
    end
  end

  int total = 0;
  int bad   = 0;

  // Reference model: accepted bytes with their accept edges, and the frame start edges
  // they imply (a frame starts one edge after acceptance, or right as the previous one ends).
  int         n_q = 0;
  int         acc_e [64];
  logic [7:0] byt   [64];
  int         st_e  [64];

  task automatic model_clear();
    n_q = 0;
  endtask

  task automatic schedule(input int cpb);
    int s;
    for (int i = 0; i < n_q; i++) begin
      s = acc_e[i] + 1;
      if (i > 0 && s < st_e[i-1] + 10 * cpb) s = st_e[i-1] + 10 * cpb;
      st_e[i] = s;
    end
  endtask

  function automatic bit exp_bit(input logic [7:0] b, input int slot);
    if (slot == 0) return 1'b0;
    if (slot >= 9) return 1'b1;
    return b[slot-1];
  endfunction

  function automatic int frame_errs(input int d, input int i, input int cpb);
    int e  = 0;
    int k0 = st_e[i];
    int ke = st_e[i] + 10 * cpb;
    for (int j = 0; j < 10 * cpb; j++) begin
      if (ser_log[d][k0+j] != exp_bit(byt[i], j / cpb)) e++;
      if (!act_log[d][k0+j]) e++;
      if (j > 0 && done_log[d][k0+j]) e++;
    end
    if (!done_log[d][ke]) e++;
    if (done_log[d][ke+1]) e++;
    if (!(i + 1 < n_q && st_e[i+1] == ke)) begin
      if (act_log[d][ke]) e++;
      if (!ser_log[d][ke]) e++;
    end
    return e;
  endfunction

  function automatic int count_errs(input int d, input int lo, input int hi);
    int e = 0;
    int x;
    for (int k = lo; k <= hi; k++) begin
      x = 0;
      for (int i = 0; i < n_q; i++) begin
        if (acc_e[i] <= k) x++;
        if (st_e[i] <= k) x--;
      end
      if (cnt_log[d][k] != x) e++;
    end
    return e;
  endfunction

  task automatic push(input int d, input logic [7:0] b, output bit ok);
    ok = 1'b0;
    if (d == 0) begin va = 1'b1; ba = b; end
    else        begin vb = 1'b1; bb = b; end
    for (int i = 0; i < 5000; i++) begin
      if (((d == 0) ? ready_a : ready_b) === 1'b1) begin
        @(negedge clk);
        ok = 1'b1;
        acc_e[n_q] = cyc;
        byt[n_q]   = b;
        n_q++;
        break;
      end
      @(negedge clk);
    end
    if (d == 0) va = 1'b0;
    else        vb = 1'b0;
  endtask

  task automatic wait_idle(input int d, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk);
      if (d == 0 && act_a === 1'b0 && cnt_a === 3'd0 && ser_a === 1'b1) begin ok = 1'b1; break; end
      if (d == 1 && act_b === 1'b0 && cnt_b === 3'd0 && ser_b === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    va = 1'b1; ba = 8'h77;
    vb = 1'b1; bb = 8'h77;
    repeat (4) @(negedge clk);
    total++; if (ser_a !== 1'b1)   begin bad++; $display("FAIL reset_serial: got %b want 1", ser_a); end
    total++; if (act_a !== 1'b0)   begin bad++; $display("FAIL reset_active: got %b want 0", act_a); end
    total++; if (done_a !== 1'b0)  begin bad++; $display("FAIL reset_done: got %b want 0", done_a); end
    total++; if (cnt_a !== 3'd0)   begin bad++; $display("FAIL reset_count: got %0d want 0", cnt_a); end
    total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready_a); end
    total++; if (ser_b !== 1'b1)   begin bad++; $display("FAIL reset_serial_fast: got %b want 1", ser_b); end
    va = 1'b0; vb = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (cnt_a !== 3'd0) begin bad++; $display("FAIL reset_input_ignored: count got %0d want 0", cnt_a); end
    total++; if (ser_a !== 1'b1) begin bad++; $display("FAIL reset_release_idle: serial got %b want 1", ser_a); end
    $display("reset: serial=%b active=%b count=%0d ready=%b", ser_a, act_a, cnt_a, ready_a);
  endtask

  task automatic test_single(input logic [7:0] b, input string name);
    bit ok;
    int e, n_act, n_done, lo, hi;
    wait_idle(0, ok);
    total++; if (!ok) begin bad++; $display("FAIL %s_idle: DUT not idle within budget", name); end
    model_clear();
    push(0, b, ok);
    total++; if (!ok) begin bad++; $display("FAIL %s_accept: byte %02h not accepted within budget", name, b); end
    schedule(CPB_A);
    hi = st_e[0] + 10 * CPB_A + 4;
    lo = acc_e[0] - 1;
    wait_until(hi + 2);
    total++; if (ser_log[0][st_e[0]-1] !== 1'b1) begin bad++; $display("FAIL %s_pre_start: serial got %b want 1", name, ser_log[0][st_e[0]-1]); end
    e = frame_errs(0, 0, CPB_A);
    total++; if (e !== 0) begin bad++; $display("FAIL %s_frame: %0d mismatched samples, want 0", name, e); end
    n_act = 0; n_done = 0;
    for (int k = lo; k <= hi; k++) begin
      if (act_log[0][k]) n_act++;
      if (done_log[0][k]) n_done++;
    end
    total++; if (n_act !== 10 * CPB_A) begin bad++; $display("FAIL %s_active_len: got %0d want %0d", name, n_act, 10 * CPB_A); end
    total++; if (n_done !== 1) begin bad++; $display("FAIL %s_done_pulses: got %0d want 1", name, n_done); end
    e = count_errs(0, lo, hi);
    total++; if (e !== 0) begin bad++; $display("FAIL %s_count: %0d mismatched cycles, want 0", name, e); end
    $display("frame %s: byte=%02h accept=%0d start=%0d active=%0d done=%0d", name, b, acc_e[0], st_e[0], n_act, n_done);
  endtask

  task automatic test_back_to_back();
    bit ok, all_ok;
    int e, n_done, lo, hi, want_acc;
    wait_idle(0, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_idle: DUT not idle within budget"); end
    model_clear();
    all_ok = 1'b1;
    for (int v = 1; v <= 5; v++) begin
      push(0, 8'(v), ok);
      all_ok &= ok;
    end
    total++; if (!all_ok) begin bad++; $display("FAIL b2b_accept: a byte was not accepted"); end
    total++; if (acc_e[4] - acc_e[0] !== 4) begin bad++; $display("FAIL b2b_consecutive: span got %0d want 4", acc_e[4] - acc_e[0]); end
    total++; if (rdy_log[0][acc_e[4]] !== 1'b0) begin bad++; $display("FAIL b2b_ready_low: got %b want 0", rdy_log[0][acc_e[4]]); end
    schedule(CPB_A);
    want_acc = st_e[1] + 1;
    push(0, 8'hFF, ok);
    total++; if (!ok || acc_e[5] !== want_acc) begin bad++; $display("FAIL hold_full_accept: edge got %0d want %0d", ok ? acc_e[5] : -1, want_acc); end
    schedule(CPB_A);
    hi = st_e[5] + 10 * CPB_A + 4;
    lo = acc_e[0] - 1;
    wait_until(hi + 2);
    for (int i = 0; i < 6; i++) begin
      e = frame_errs(0, i, CPB_A);
      total++; if (e !== 0) begin bad++; $display("FAIL b2b_frame%0d: %0d mismatched samples, want 0", i, e); end
      $display("frame b2b: byte=%02h accept=%0d start=%0d errs=%0d", byt[i], acc_e[i], st_e[i], e);
    end
    n_done = 0;
    for (int k = lo; k <= hi; k++) if (done_log[0][k]) n_done++;
    total++; if (n_done !== 6) begin bad++; $display("FAIL b2b_done_pulses: got %0d want 6", n_done); end
    e = count_errs(0, lo, hi);
    total++; if (e !== 0) begin bad++; $display("FAIL b2b_count: %0d mismatched cycles, want 0", e); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int r0, n_low, n_done, n_act, n_cnt;
    wait_idle(0, ok);
    total++; if (!ok) begin bad++; $display("FAIL rst_mid_idle: DUT not idle within budget"); end
    model_clear();
    push(0, 8'h00, ok);
    push(0, 8'h12, ok);
    schedule(CPB_A);
    wait_until(st_e[0] + 4 * CPB_A + 100);
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (ser_a !== 1'b1)   begin bad++; $display("FAIL rst_mid_serial: got %b want 1", ser_a); end
    total++; if (cnt_a !== 3'd0)   begin bad++; $display("FAIL rst_mid_count: got %0d want 0", cnt_a); end
    total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL rst_mid_ready: got %b want 1", ready_a); end
    total++; if (act_a !== 1'b0)   begin bad++; $display("FAIL rst_mid_active: got %b want 0", act_a); end
    r0 = cyc;
    va = 1'b1; ba = 8'h77;
    repeat (3) @(negedge clk);
    total++; if (cnt_a !== 3'd0) begin bad++; $display("FAIL rst_mid_push_ignored: count got %0d want 0", cnt_a); end
    va = 1'b0;
    rst_n = 1'b1;
    wait_until(r0 + 2600);
    n_low = 0; n_done = 0; n_act = 0; n_cnt = 0;
    for (int k = r0 + 1; k <= r0 + 2590; k++) begin
      if (!ser_log[0][k]) n_low++;
      if (done_log[0][k]) n_done++;
      if (act_log[0][k]) n_act++;
      if (cnt_log[0][k] != 0) n_cnt++;
    end
    total++; if (n_low !== 0)  begin bad++; $display("FAIL rst_mid_line_idle: low cycles got %0d want 0", n_low); end
    total++; if (n_done !== 0) begin bad++; $display("FAIL rst_mid_no_done: pulses got %0d want 0", n_done); end
    total++; if (n_act !== 0)  begin bad++; $display("FAIL rst_mid_no_active: cycles got %0d want 0", n_act); end
    total++; if (n_cnt !== 0)  begin bad++; $display("FAIL rst_mid_fifo_flushed: nonzero cycles got %0d want 0", n_cnt); end
    $display("reset mid-frame at edge %0d: low=%0d done=%0d active=%0d", r0, n_low, n_done, n_act);
  endtask

  task automatic test_random_fast();
    bit ok, all_ok;
    int e, n_done, lo, hi;
    logic [7:0] rb;
    wait_idle(1, ok);
    total++; if (!ok) begin bad++; $display("FAIL rnd_idle: fast DUT not idle within budget"); end
    model_clear();
    all_ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 40)) @(negedge clk);
      rb = 8'($urandom);
      push(1, rb, ok);
      all_ok &= ok;
    end
    total++; if (!all_ok) begin bad++; $display("FAIL rnd_accept: a byte was not accepted"); end
    schedule(CPB_B);
    hi = st_e[n_q-1] + 10 * CPB_B + 4;
    lo = acc_e[0] - 1;
    wait_until(hi + 2);
    for (int i = 0; i < n_q; i++) begin
      e = frame_errs(1, i, CPB_B);
      total++; if (e !== 0) begin bad++; $display("FAIL rnd_frame%0d: byte %02h %0d mismatched samples, want 0", i, byt[i], e); end
      $display("frame fast: byte=%02h accept=%0d start=%0d errs=%0d", byt[i], acc_e[i], st_e[i], e);
    end
    n_done = 0;
    for (int k = lo; k <= hi; k++) if (done_log[1][k]) n_done++;
    total++; if (n_done !== n_q) begin bad++; $display("FAIL rnd_done_pulses: got %0d want %0d", n_done, n_q); end
    e = count_errs(1, lo, hi);
    total++; if (e !== 0) begin bad++; $display("FAIL rnd_count: %0d mismatched cycles, want 0", e); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    va = 1'b0; ba = 8'h00;
    vb = 1'b0; bb = 8'h00;
    test_reset();
    test_single(8'h55, "byte55");
    test_single(8'hA3, "byteA3");
    test_back_to_back();
    test_reset_mid_frame();
    test_random_fast();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
